// File: rtl/pc_sequencer.sv
// rtl/pc_sequencer.sv - PC sequencer: step/branch/call/ret command FSM with return-address stack
module pc_sequencer #(
    parameter int DEPTH = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        run,
    input  logic [11:0] pc,
    input  logic        step,
    input  logic        branch,
    input  logic        call,
    input  logic        ret,
    input  logic [11:0] target,
    output logic        pc_load,
    output logic        pc_enable,
    output logic [11:0] pc_value,
    output logic        stack_empty,
    output logic        stack_full,
    output logic        err
);

    localparam int DW = $clog2(DEPTH + 1);
    localparam int AW = $clog2(DEPTH);

    typedef enum logic [1:0] {IDLE, RUN, FAULT} state_e;

    state_e        state_q, state_d;
    logic          load_q, load_d;
    logic          enable_q, enable_d;
    logic [11:0]   value_q, value_d;
    logic          err_q, err_d;
    logic [DW-1:0] depth_q, depth_d;
    logic          push;
    logic [11:0]   stack_q [DEPTH];
    logic [AW-1:0] top_idx;
    logic [AW-1:0] push_idx;

    assign top_idx     = AW'(depth_q - DW'(1));
    assign push_idx    = AW'(depth_q);
    assign stack_empty = (depth_q == '0);
    assign stack_full  = (depth_q == DW'(DEPTH));
    assign pc_load     = load_q;
    assign pc_enable   = enable_q;
    assign pc_value    = value_q;
    assign err         = err_q;

    always_comb begin
        state_d  = state_q;
        load_d   = 1'b0;
        enable_d = 1'b0;
        value_d  = value_q;
        err_d    = err_q;
        depth_d  = depth_q;
        push     = 1'b0;
        case (state_q)
            IDLE: begin
                if (run) state_d = RUN;
            end
            RUN: begin
                // One command per cycle; ret > call > branch > step, losers are dropped.
                if (!run) begin
                    state_d = IDLE;
                end else if (ret) begin
                    if (stack_empty) begin
                        err_d   = 1'b1;
                        state_d = FAULT;
                    end else begin
                        depth_d = depth_q - DW'(1);
                        load_d  = 1'b1;
                        value_d = stack_q[top_idx];
                    end
                end else if (call) begin
                    if (stack_full) begin
                        err_d   = 1'b1;
                        state_d = FAULT;
                    end else begin
                        push    = 1'b1;
                        depth_d = depth_q + DW'(1);
                        load_d  = 1'b1;
                        value_d = target;
                    end
                end else if (branch) begin
                    load_d  = 1'b1;
                    value_d = target;
                end else if (step) begin
                    enable_d = 1'b1;
                end
            end
            default: begin
                state_d = FAULT;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= IDLE;
            load_q   <= 1'b0;
            enable_q <= 1'b0;
            value_q  <= 12'h000;
            err_q    <= 1'b0;
            depth_q  <= '0;
        end else begin
            state_q  <= state_d;
            load_q   <= load_d;
            enable_q <= enable_d;
            value_q  <= value_d;
            err_q    <= err_d;
            depth_q  <= depth_d;
        end
    end

    // Contents are left alone on reset; a zero depth makes them unreachable.
    always_ff @(posedge clk) begin
        if (push) stack_q[push_idx] <= pc + 12'd1;
    end

endmodule

// File: tb/tb_pc_sequencer.sv
// tb/tb_pc_sequencer.sv - scoreboard bench for pc_sequencer
module tb_pc_sequencer;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        run = 1'b0;
    logic [11:0] pc = 12'h000;
    logic        step = 1'b0;
    logic        branch = 1'b0;
    logic        call = 1'b0;
    logic        ret = 1'b0;
    logic [11:0] target = 12'h000;
    logic        pc_load;
    logic        pc_enable;
    logic [11:0] pc_value;
    logic        stack_empty;
    logic        stack_full;
    logic        err;

    pc_sequencer #(.DEPTH(4)) dut (
        .clk(clk), .reset(reset), .run(run), .pc(pc),
        .step(step), .branch(branch), .call(call), .ret(ret), .target(target),
        .pc_load(pc_load), .pc_enable(pc_enable), .pc_value(pc_value),
        .stack_empty(stack_empty), .stack_full(stack_full), .err(err)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit          ld;
        bit          en;
        logic [11:0] val;
        int          due;
    } exp_t;

    exp_t exp_q[$];
    int   cyc = 0;
    int   n_chk = 0;
    int   n_fail = 0;

    always @(posedge clk) cyc++;

    task automatic chk(input string name, input int act, input int req);
        n_chk++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // Monitor: every strobe must match the oldest expected entry in the cycle it is due.
    always @(negedge clk) begin
        if (exp_q.size() > 0 && exp_q[0].due < cyc) begin
            chk("missing_strobe_due", exp_q[0].due, cyc);
            void'(exp_q.pop_front());
        end
        if (pc_load === 1'b1 || pc_enable === 1'b1) begin
            chk("load_and_enable_exclusive", int'(pc_load & pc_enable), 0);
            if (exp_q.size() == 0) begin
                chk("unexpected_strobe", 1, 0);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                chk("strobe_cycle", cyc, e.due);
                chk("pc_load", int'(pc_load), int'(e.ld));
                chk("pc_enable", int'(pc_enable), int'(e.en));
                if (e.ld) chk("pc_value", int'(pc_value), int'(e.val));
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic expect_strobe(input bit ld, input bit en, input logic [11:0] val);
        exp_t e;
        e.ld = ld; e.en = en; e.val = val; e.due = cyc + 1;
        exp_q.push_back(e);
    endtask

    task automatic issue(input bit s, input bit b, input bit c, input bit r,
                         input logic [11:0] p, input logic [11:0] t);
        step = s; branch = b; call = c; ret = r; pc = p; target = t;
        tick();
        step = 0; branch = 0; call = 0; ret = 0;
    endtask

    task automatic do_reset();
        reset = 0;
        tick();
        reset = 1;
        tick();
    endtask

    initial begin
        tick();
        chk("rst_pc_load", int'(pc_load), 0);
        chk("rst_pc_enable", int'(pc_enable), 0);
        chk("rst_pc_value", int'(pc_value), 0);
        chk("rst_err", int'(err), 0);
        chk("rst_empty", int'(stack_empty), 1);
        chk("rst_full", int'(stack_full), 0);
        reset = 1;
        tick();

        // Requests while IDLE are ignored
        issue(1, 1, 0, 0, 12'h000, 12'h0AA);
        issue(1, 0, 0, 0, 12'h000, 12'h000);

        // Enter RUN, then three steps
        run = 1;
        tick();
        step = 1;
        for (int i = 0; i < 3; i++) begin
            expect_strobe(0, 1, 12'h000);
            tick();
        end
        step = 0;
        tick();

        // call / branch / ret
        expect_strobe(1, 0, 12'h200);
        issue(0, 0, 1, 0, 12'h010, 12'h200);
        chk("call_empty_falls", int'(stack_empty), 0);
        expect_strobe(1, 0, 12'h123);
        issue(0, 1, 0, 0, 12'h200, 12'h123);
        chk("branch_keeps_depth", int'(stack_empty), 0);
        expect_strobe(1, 0, 12'h011);
        issue(0, 0, 0, 1, 12'h123, 12'h000);
        chk("ret_empty_rises", int'(stack_empty), 1);

        // Wrap-around of the return address
        expect_strobe(1, 0, 12'h005);
        issue(0, 0, 1, 0, 12'hFFF, 12'h005);
        expect_strobe(1, 0, 12'h000);
        issue(0, 0, 0, 1, 12'h005, 12'h000);

        // All four requests with depth 1: only ret
        expect_strobe(1, 0, 12'h300);
        issue(0, 0, 1, 0, 12'h020, 12'h300);
        expect_strobe(1, 0, 12'h021);
        issue(1, 1, 1, 1, 12'h050, 12'h777);
        chk("priority_pop_empty", int'(stack_empty), 1);
        tick();

        // Dropping run preserves the stack
        expect_strobe(1, 0, 12'h040);
        issue(0, 0, 1, 0, 12'h100, 12'h040);
        run = 0;
        issue(1, 0, 0, 0, 12'h040, 12'h000);
        chk("idle_keeps_stack", int'(stack_empty), 0);
        run = 1;
        tick();
        expect_strobe(1, 0, 12'h101);
        issue(0, 0, 0, 1, 12'h040, 12'h000);

        // Reset while a branch strobe is due
        expect_strobe(1, 0, 12'h060);
        issue(0, 0, 1, 0, 12'h030, 12'h060);
        branch = 1; target = 12'h0AB;
        @(posedge clk);
        #1;
        reset = 0;
        branch = 0;
        #1;
        chk("midrst_pc_load", int'(pc_load), 0);
        chk("midrst_empty", int'(stack_empty), 1);
        chk("midrst_err", int'(err), 0);
        run = 0;
        @(negedge clk);
        tick();
        reset = 1;
        run = 1;
        tick();
        tick();

        // Overflow into FAULT
        for (int i = 0; i < 4; i++) begin
            expect_strobe(1, 0, 12'h400 + 12'(i));
            issue(0, 0, 1, 0, 12'(i), 12'h400 + 12'(i));
            chk("fill_full", int'(stack_full), (i == 3) ? 1 : 0);
        end
        issue(0, 0, 1, 0, 12'h004, 12'h404);
        chk("overflow_err", int'(err), 1);
        chk("overflow_full_kept", int'(stack_full), 1);
        issue(1, 0, 0, 0, 12'h004, 12'h000);
        issue(0, 0, 0, 1, 12'h004, 12'h000);
        issue(1, 0, 0, 0, 12'h004, 12'h000);
        chk("fault_sticky", int'(err), 1);
        do_reset();
        chk("fault_cleared_err", int'(err), 0);
        chk("fault_cleared_full", int'(stack_full), 0);

        // Underflow into FAULT
        tick();
        issue(0, 0, 0, 1, 12'h000, 12'h000);
        chk("underflow_err", int'(err), 1);
        issue(1, 0, 0, 0, 12'h000, 12'h000);
        do_reset();

        repeat (3) tick();
        chk("scoreboard_drained", exp_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #50000;
        $display("FAIL timeout: simulation did not finish, expected end by 50000");
        $fatal(1);
    end

endmodule
